// File: rtl/led_indicator_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | led_indicator_pkg : shared types and default constants for the LED driver   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package led_indicator_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        FOLLOW = 2'd2
    } led_state_t;

    localparam int c_n_led      = 4;
    localparam int c_prescale   = 1000;
    localparam int c_hold_ticks = 50;
    localparam int c_pwm_bits   = 4;

endpackage
`default_nettype wire

// File: rtl/led_indicator_driver_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | led_indicator_driver_if : status-in / pad-out bundle of the LED driver      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface led_indicator_driver_if
    import led_indicator_pkg::*;
#(
    parameter int N_LED    = c_n_led,
    parameter int PWM_BITS = c_pwm_bits
);

    logic [N_LED-1:0]    led_in;
    logic [PWM_BITS-1:0] brightness;
    logic [N_LED-1:0]    led_out;
    logic                tick;

    // master: the SoC side feeding status and brightness
    modport master (
        output led_in,
        output brightness,
        input  led_out,
        input  tick
    );

    modport slave (
        input  led_in,
        input  brightness,
        output led_out,
        output tick
    );

endinterface
`default_nettype wire

// File: rtl/led_stretch_ch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | led_stretch_ch : per-channel pulse stretcher (IDLE/HOLD/FOLLOW + hold_cnt)  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module led_stretch_ch
    import led_indicator_pkg::*;
#(
    parameter int HOLD_TICKS = c_hold_ticks
)
(
    input  wire  clk,
    input  wire  reset,
    input  wire  tick,
    input  wire  level,
    input  wire  rise,
    output logic s
);

    localparam int                 c_cnt_w     = $clog2(HOLD_TICKS + 1);
    localparam logic [c_cnt_w-1:0] c_hold_load = c_cnt_w'(HOLD_TICKS);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

    led_state_t         r_state;
    led_state_t         w_state_nxt;
    logic [c_cnt_w-1:0] r_hold_cnt;
    logic [c_cnt_w-1:0] w_hold_cnt_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_hold_cnt_nxt = r_hold_cnt;
        case (r_state)
            IDLE: begin
                if (rise) begin
                    w_state_nxt    = HOLD;
                    w_hold_cnt_nxt = c_hold_load;
                end
            end
            HOLD: begin
                // a retrigger reload wins over a coincident tick
                if (rise) begin
                    w_hold_cnt_nxt = c_hold_load;
                end else if (tick) begin
                    w_hold_cnt_nxt = r_hold_cnt - c_cnt_one;
                    if (r_hold_cnt == c_cnt_one) begin
                        w_state_nxt = level ? FOLLOW : IDLE;
                    end
                end
            end
            FOLLOW: begin
                if (!level) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign s = (r_state != IDLE);

endmodule
`default_nettype wire

// File: rtl/led_indicator_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | led_indicator_driver : pulse-stretching, PWM-dimmed drive for board LEDs.   |
// | Stretching is compiled in only with LED_STRETCH_EN defined.   Rev 1.0       |
// +----------------------------------------------------------------------------+
module led_indicator_driver
    import led_indicator_pkg::*;
#(
    parameter int N_LED      = c_n_led,
    parameter int PRESCALE   = c_prescale,
    parameter int HOLD_TICKS = c_hold_ticks,
    parameter int PWM_BITS   = c_pwm_bits
)
(
    input wire                    clk,
    input wire                    reset,
    led_indicator_driver_if.slave bus
);

    localparam logic [PWM_BITS-1:0] c_pwm_max = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] c_pwm_one = PWM_BITS'(1);

    if (PRESCALE < 2 || HOLD_TICKS < 1) begin : g_cfg_err
        $error("led_indicator_driver: PRESCALE must be >= 2 and HOLD_TICKS >= 1");
    end

    logic [N_LED-1:0]    r_led_q;
    logic [N_LED-1:0]    w_s;
    logic                w_tick;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [PWM_BITS-1:0] r_bright_q;
    logic                w_pwm_on;
    logic [N_LED-1:0]    r_led_out;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_led_q <= '0;
        end else begin
            r_led_q <= bus.led_in;
        end
    end

`ifdef LED_STRETCH_EN
    localparam int                 c_pre_w    = $clog2(PRESCALE);
    localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(PRESCALE - 1);
    localparam logic [c_pre_w-1:0] c_pre_one  = c_pre_w'(1);

    logic [N_LED-1:0]   r_led_q_prev;
    logic [N_LED-1:0]   w_rise;
    logic [c_pre_w-1:0] r_pre_cnt;

    // free-running: channel activity never realigns the tick phase
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_led_q_prev <= '0;
            r_pre_cnt    <= '0;
        end else begin
            r_led_q_prev <= r_led_q;
            r_pre_cnt    <= (r_pre_cnt == c_pre_last) ? '0 : (r_pre_cnt + c_pre_one);
        end
    end

    assign w_tick = (r_pre_cnt == c_pre_last);
    assign w_rise = r_led_q & ~r_led_q_prev;

    for (genvar gi = 0; gi < N_LED; gi++) begin : g_ch
        led_stretch_ch #(
            .HOLD_TICKS (HOLD_TICKS)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .tick  (w_tick),
            .level (r_led_q[gi]),
            .rise  (w_rise[gi]),
            .s     (w_s[gi])
        );
    end
`else
    assign w_s    = r_led_q;
    assign w_tick = 1'b0;
`endif

    // brightness is only picked up at the period boundary so a duty change never glitches
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pwm_cnt  <= '0;
            r_bright_q <= c_pwm_max;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + c_pwm_one;
            if (r_pwm_cnt == c_pwm_max) begin
                r_bright_q <= bus.brightness;
            end
        end
    end

    assign w_pwm_on = (r_bright_q == c_pwm_max) | (r_pwm_cnt < r_bright_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_led_out <= '0;
        end else begin
            r_led_out <= w_s & {N_LED{w_pwm_on}};
        end
    end

    assign bus.led_out = r_led_out;
    assign bus.tick    = w_tick;

endmodule
`default_nettype wire
